multi_signal_history_tracker: RTL and testbench
===============================================

// Module: multi_signal_history_tracker
// PURPOSE
//  Multi-channel successor to the single-signal tracker. It samples NUM_CH trace signals every enabled
//  cycle into a circular history of DEPTH entries, tagged by a free-running timestamp.
//  Retrospective queries (recall, occurrence, first-high, rising-edge) arrive over a valid/ready request
//  port and are answered over a valid/ready response port.
//  Sits beside the trace FSMs, which ask "when did X happen" after the fact.
// PARAMETERS
//  NUM_CH   4    number of tracked single-bit channels (>=1)
//  DEPTH    16   history entries per channel; power of 2, >=4
//  TIME_W   32   timestamp width; wraps modulo 2^TIME_W
// PORTS
//  clk         in   1               sampling/FSM clock, rising edge
//  rst_n       in   1               reset, asynchronous, active-high
//  sample_en   in   1               1: capture sig_i and advance timestamp this cycle
//  sig_i       in   NUM_CH          channel values to record
//  now_o       out  TIME_W          timestamp the next sample will be written at
//  full_o      out  1               history holds DEPTH valid entries
//  q_valid_i   in   1               query request valid
//  q_ready_o   out  1               query accepted when q_valid_i&&q_ready_o
//  q_op_i      in   2               00 RECALL, 01 ANY, 10 FIRST, 11 RISE
//  q_ch_i      in   $clog2(NUM_CH)  channel queried (clog2 floored at 1)
//  q_t0_i      in   TIME_W          range start (RECALL uses only t0)
//  q_t1_i      in   TIME_W          range end, inclusive
//  r_valid_o   out  1               response valid; held until r_ready_i
//  r_ready_i   in   1               response consumed
//  r_hit_o     out  1               RECALL: stored bit; other ops: condition found
//  r_time_o    out  TIME_W          timestamp of hit (RECALL: t0); 0 when no hit
//  r_err_o     out  1               range invalid or overwritten during scan
// BEHAVIOUR
//  Reset (async, while rst_n=1): now_o=0, fill=0, full_o=0, FSM=IDLE, q_ready_o=0,
//    r_valid_o=0, r_hit_o=0, r_time_o=0, r_err_o=0. Buffer RAM is not cleared; fill=0 invalidates it.
//  Reset mid-query aborts the query silently; no response is issued.
//  Sampling: at each posedge with sample_en=1, write sig_i to slot now[log2 DEPTH-1:0], then now++ and
//    fill=min(fill+1,DEPTH). Sampling continues in every FSM state.
//  Age: age(t) = now - t, unsigned modulo 2^TIME_W. Entry t is valid iff 1 <= age(t) <= fill.
//  FSM states IDLE -> CHECK -> SCAN -> RESP -> IDLE. q_ready_o=1 only in IDLE.
//  CHECK (1 cycle): err if t0 or t1 invalid, or age(t0) < age(t1) for non-RECALL ops.
//    On err, go to RESP with r_err_o=1, r_hit_o=0.
//  SCAN: reads one entry per cycle, t = t0 upward to t1. Before each read it re-checks validity;
//    if the entry was overwritten, go to RESP with r_err_o=1.
//  RECALL reads t0 only.
//  ANY and FIRST stop at the first entry equal to 1.
//  RISE stops at the first t with sig[t]=1 && sig[t-1]=0. sig[t-1] must itself be valid;
//    t == oldest valid entry never counts as a rise. Previous bit is carried in a register.
//  Hit sets r_hit_o=1 and r_time_o=t. Reaching t1 without a hit gives r_hit_o=0, r_time_o=0.
//  Latency accept->r_valid_o: 2 + entries scanned (RECALL = 3 cycles).
//  RESP: r_valid_o=1 with fields stable until r_valid_o&&r_ready_i. IDLE follows the next cycle,
//    so back-to-back queries are spaced >= 1 idle cycle.
//  Timestamp wrap: all comparisons use age, so ranges spanning now wrap 2^TIME_W-1 -> 0 are legal.
//  Same-cycle write of slot s and read of slot s: the read returns the old data, and the
//    validity check flags it as overwritten.
//  q_ch_i >= NUM_CH is treated as r_err_o=1.
// TESTING
//  1 Reset, 5 samples ch0=1,0,1,1,0 at t=0..4; RECALL ch0 t0=2 -> r_hit=1, r_time=2, r_err=0,
//    r_valid 3 cycles after accept.
//  2 Same history; RISE ch0 t0=0,t1=4 -> r_hit=1, r_time=2 (t=0 is oldest, not a rise).
//  3 DEPTH=16, sample 20 cycles; ANY t0=2,t1=6 -> r_err=1 (age > fill).
//    FIRST t0=5,t1=19 on a channel high only at t=12 -> r_time=12.
//  4 Query t0 = oldest valid entry with sample_en=1 and a 10-entry scan -> r_err=1 (overwrite abort).
//  5 Preload now=2^32-3; sample 6 cycles with ch1 high at t=2^32-1;
//    FIRST ch1 t0=2^32-3,t1=2 -> r_time=2^32-1.
//  6 Hold r_ready_i=0 for 5 cycles: r_* stable and q_ready_o=0; assert rst_n mid-SCAN -> all
//    outputs at reset values next edge, no response.

Source files
------------

// File: rtl/multi_signal_history_tracker.sv
// multi_signal_history_tracker: circular multi-channel trace history with a
// valid/ready retrospective query port (recall / any / first / rise).
module multi_signal_history_tracker #(
  parameter int NUM_CH = 4,
  parameter int DEPTH = 16,
  parameter int TIME_W = 32,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [NUM_CH-1:0] sig_i,
  output logic [TIME_W-1:0] now_o,
  output logic              full_o,
  input  logic              q_valid_i,
  output logic              q_ready_o,
  input  logic [1:0]        q_op_i,
  input  logic [CHW-1:0]    q_ch_i,
  input  logic [TIME_W-1:0] q_t0_i,
  input  logic [TIME_W-1:0] q_t1_i,
  output logic              r_valid_o,
  input  logic              r_ready_i,
  output logic              r_hit_o,
  output logic [TIME_W-1:0] r_time_o,
  output logic              r_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = 2 ** CHW;
  localparam logic [1:0] OP_RECALL = 2'd0;
  localparam logic [1:0] OP_RISE = 2'd3;

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, RESP} state_t;

  state_t state_q, state_d;
  logic [TIME_W-1:0] now_q;
  logic [FW-1:0] fill_q;
  logic [NUM_CH-1:0] mem [DEPTH];

  logic [1:0] op_q, op_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [TIME_W-1:0] t_q, t_d, t1_q, t1_d;
  logic prev_q, prev_d, pv_q, pv_d;
  logic hit_q, hit_d, err_q, err_d;
  logic [TIME_W-1:0] time_q, time_d;

  logic [TIME_W-1:0] fill_w, age_cur, age_t1;
  logic [AW-1:0] idx_cur, idx_prev;
  logic [CW-1:0] word_cur, word_prev;
  logic cur_ok, t1_ok, prev_ok, ch_ok;
  logic ovw, rd_bit, rd_prev, range_err, found;

  assign fill_w = TIME_W'(fill_q);
  assign age_cur = now_q - t_q;
  assign age_t1 = now_q - t1_q;
  assign cur_ok = (age_cur != '0) && (age_cur <= fill_w);
  assign t1_ok = (age_t1 != '0) && (age_t1 <= fill_w);
  assign prev_ok = cur_ok && ((age_cur + TIME_W'(1)) <= fill_w);
  assign ch_ok = int'(ch_q) < NUM_CH;
  // the oldest slot is rewritten at this edge; its data is gone after it
  assign ovw = sample_en && (age_cur == TIME_W'(DEPTH));

  assign idx_cur = t_q[AW-1:0];
  assign idx_prev = idx_cur - AW'(1);
  assign word_cur = CW'(mem[idx_cur]);
  assign word_prev = CW'(mem[idx_prev]);
  assign rd_bit = ch_ok && word_cur[ch_q];
  assign rd_prev = ch_ok && word_prev[ch_q];

  assign range_err = !ch_ok || !cur_ok ||
    ((op_q != OP_RECALL) && (!t1_ok || (age_cur < age_t1)));
  assign found = (op_q == OP_RISE) ?
    (rd_bit && pv_q && !prev_q) : rd_bit;

  always_comb begin
    state_d = state_q;
    op_d = op_q;
    ch_d = ch_q;
    t_d = t_q;
    t1_d = t1_q;
    prev_d = prev_q;
    pv_d = pv_q;
    hit_d = hit_q;
    time_d = time_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: begin
        if (q_valid_i) begin
          state_d = CHECK;
          op_d = q_op_i;
          ch_d = q_ch_i;
          t_d = q_t0_i;
          t1_d = q_t1_i;
        end
      end
      CHECK: begin
        if (range_err) begin
          state_d = RESP;
          hit_d = 1'b0;
          time_d = '0;
          err_d = 1'b1;
        end else begin
          state_d = SCAN;
          prev_d = rd_prev;
          pv_d = prev_ok;
        end
      end
      SCAN: begin
        if (!cur_ok || ovw) begin
          state_d = RESP;
          hit_d = 1'b0;
          time_d = '0;
          err_d = 1'b1;
        end else if (op_q == OP_RECALL) begin
          state_d = RESP;
          hit_d = rd_bit;
          time_d = t_q;
          err_d = 1'b0;
        end else if (found) begin
          state_d = RESP;
          hit_d = 1'b1;
          time_d = t_q;
          err_d = 1'b0;
        end else if (t_q == t1_q) begin
          state_d = RESP;
          hit_d = 1'b0;
          time_d = '0;
          err_d = 1'b0;
        end else begin
          t_d = t_q + TIME_W'(1);
          prev_d = rd_bit;
          pv_d = 1'b1;
        end
      end
      RESP: begin
        if (r_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      ch_q <= '0;
      t_q <= '0;
      t1_q <= '0;
      prev_q <= 1'b0;
      pv_q <= 1'b0;
      hit_q <= 1'b0;
      time_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      ch_q <= ch_d;
      t_q <= t_d;
      t1_q <= t1_d;
      prev_q <= prev_d;
      pv_q <= pv_d;
      hit_q <= hit_d;
      time_q <= time_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      now_q <= '0;
      fill_q <= '0;
    end else if (sample_en) begin
      now_q <= now_q + TIME_W'(1);
      if (fill_q != FW'(DEPTH)) fill_q <= fill_q + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sample_en) mem[now_q[AW-1:0]] <= sig_i;
  end

  assign now_o = now_q;
  assign full_o = fill_q == FW'(DEPTH);
  assign q_ready_o = (state_q == IDLE) && !rst_n;
  assign r_valid_o = state_q == RESP;
  assign r_hit_o = hit_q;
  assign r_time_o = time_q;
  assign r_err_o = err_q;

endmodule

// File: tb/tb_multi_signal_history_tracker.sv
// Bench for multi_signal_history_tracker: directed scenarios plus random
// queries checked every cycle against a timestamp-indexed history model.
module tb_multi_signal_history_tracker;

  localparam int NCH = 3;
  localparam int DEP = 16;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic sample_en;
  logic [NCH-1:0] sig_i;
  logic [TW-1:0] now_o;
  logic full_o;
  logic q_valid, q_ready_o;
  logic [1:0] q_op;
  logic [1:0] q_ch;
  logic [TW-1:0] q_t0, q_t1;
  logic r_valid_o, r_ready;
  logic r_hit_o;
  logic [TW-1:0] r_time_o;
  logic r_err_o;

  multi_signal_history_tracker #(
    .NUM_CH(NCH), .DEPTH(DEP), .TIME_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .sig_i(sig_i),
    .now_o(now_o), .full_o(full_o), .q_valid_i(q_valid),
    .q_ready_o(q_ready_o), .q_op_i(q_op), .q_ch_i(q_ch),
    .q_t0_i(q_t0), .q_t1_i(q_t1), .r_valid_o(r_valid_o),
    .r_ready_i(r_ready), .r_hit_o(r_hit_o), .r_time_o(r_time_o),
    .r_err_o(r_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit run = 0;
  bit rnd_samp = 0;
  int pct = 50;

  // model: history by timestamp, plus a per-cycle log of now/fill/en
  logic [3:0] hist [256];
  bit en_l [32768];
  logic [TW-1:0] now_l [32768];
  int fill_l [32768];
  logic [TW-1:0] mnow = '0;
  int mfill = 0;
  bit m_busy = 0, m_done = 0, m_hit = 0, m_err = 0;
  int m_dc = 0;
  logic [TW-1:0] m_time = '0;
  int qa;
  logic [1:0] qop, qch;
  logic [TW-1:0] qt0, qt1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic bit okv(input logic [TW-1:0] ag, input int f);
    return (ag != 0) && (int'(ag) <= f);
  endfunction

  // Outcome of the pending query as far as the logged cycles allow.
  function automatic void eval_q(input int upto, output bit dn,
      output int dc, output bit h, output logic [TW-1:0] tm, output bit e);
    int c;
    logic [TW-1:0] t, ag, ag1;
    bit pv, pr, b;
    dn = 0; dc = 0; h = 0; tm = '0; e = 0;
    c = qa + 1;
    if (c > upto) return;
    ag = now_l[c] - qt0;
    ag1 = now_l[c] - qt1;
    if (int'(qch) >= NCH || !okv(ag, fill_l[c]) ||
        (qop != 0 && (!okv(ag1, fill_l[c]) || ag < ag1))) begin
      dn = 1; dc = c; e = 1; return;
    end
    pv = (int'(ag) + 1 <= fill_l[c]);
    pr = hist[qt0 - 8'd1][qch];
    t = qt0;
    for (int i = 0; i < 300; i++) begin
      c = qa + 2 + i;
      if (c > upto) return;
      ag = now_l[c] - t;
      if (!okv(ag, fill_l[c]) || int'(ag) + int'(en_l[c]) > DEP) begin
        dn = 1; dc = c; e = 1; return;
      end
      b = hist[t][qch];
      if (qop == 0) begin
        dn = 1; dc = c; h = b; tm = t; return;
      end
      if ((qop != 3 && b) || (qop == 3 && b && pv && !pr)) begin
        dn = 1; dc = c; h = 1; tm = t; return;
      end
      if (t == qt1) begin
        dn = 1; dc = c; return;
      end
      pr = b; pv = 1; t = t + 8'd1;
    end
  endfunction

  always @(posedge clk) begin
    en_l[cyc] = sample_en;
    now_l[cyc] = mnow;
    fill_l[cyc] = mfill;
    if (rst_n) begin
      mnow = '0; mfill = 0; m_busy = 0; m_done = 0;
    end else begin
      if (m_busy && m_done && r_ready) m_busy = 0;
      else if (!m_busy && q_valid) begin
        m_busy = 1; m_done = 0; qa = cyc;
        qop = q_op; qch = q_ch; qt0 = q_t0; qt1 = q_t1;
      end
      if (sample_en) begin
        hist[mnow] = 4'(sig_i);
        mnow = mnow + 8'd1;
        if (mfill < DEP) mfill++;
      end
      if (m_busy && !m_done)
        eval_q(cyc, m_done, m_dc, m_hit, m_time, m_err);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (run) begin
      if (rst_n) begin
        chk("rst_now", now_o, 0);
        chk("rst_full", full_o, 0);
        chk("rst_q_ready", q_ready_o, 0);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_r_hit", r_hit_o, 0);
        chk("rst_r_time", r_time_o, 0);
        chk("rst_r_err", r_err_o, 0);
      end else begin
        chk("now", now_o, mnow);
        chk("full", full_o, mfill == DEP);
        chk("q_ready", q_ready_o, !m_busy);
        chk("r_valid", r_valid_o, m_busy && m_done);
        if (m_busy && m_done) begin
          chk("r_hit", r_hit_o, m_hit);
          chk("r_time", r_time_o, m_time);
          chk("r_err", r_err_o, m_err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_samp) begin
      sample_en = ($urandom_range(0, 99) < pct);
      sig_i = NCH'($urandom);
    end
  endtask

  task automatic do_query(input logic [1:0] op, input logic [1:0] ch,
      input logic [TW-1:0] t0, input logic [TW-1:0] t1, input int hold,
      output logic h, output logic [TW-1:0] tm, output logic e,
      output int lat);
    int n;
    q_op = op; q_ch = ch; q_t0 = t0; q_t1 = t1; q_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!q_ready_o && n < 60) begin
      tick(); @(negedge clk); n++;
    end
    chk("q_ready_wait", q_ready_o, 1);
    tick();
    q_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!r_valid_o && lat < 60) begin
      tick(); lat++; @(negedge clk);
    end
    chk("r_valid_wait", r_valid_o, 1);
    h = r_hit_o; tm = r_time_o; e = r_err_o;
    for (int i = 0; i < hold; i++) begin
      tick(); @(negedge clk);
      chk("hold_r_valid", r_valid_o, 1);
      chk("hold_q_ready", q_ready_o, 0);
    end
    tick();
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
  endtask

  logic h, e;
  logic [TW-1:0] tm;
  int lat;

  initial begin
    rst_n = 1'b1;
    sample_en = 1'b0; sig_i = '0;
    q_valid = 1'b0; q_op = '0; q_ch = '0; q_t0 = '0; q_t1 = '0;
    r_ready = 1'b0;
    repeat (3) tick();
    run = 1;
    tick();
    rst_n = 1'b0;

    // five samples ch0 = 1,0,1,1,0 at t=0..4
    for (int i = 0; i < 5; i++) begin
      sample_en = 1'b1;
      sig_i = {2'b00, (i == 0 || i == 2 || i == 3)};
      tick();
    end
    sample_en = 1'b0; sig_i = '0;
    do_query(2'd0, 2'd0, 8'd2, 8'd2, 0, h, tm, e, lat);
    chk("t1_recall_hit", h, 1);
    chk("t1_recall_time", tm, 2);
    chk("t1_recall_err", e, 0);
    chk("t1_recall_lat", lat, 3);
    do_query(2'd3, 2'd0, 8'd0, 8'd4, 0, h, tm, e, lat);
    chk("t2_rise_hit", h, 1);
    chk("t2_rise_time", tm, 2);
    chk("t2_rise_lat", lat, 5);
    do_query(2'd0, 2'd0, 8'd1, 8'd1, 0, h, tm, e, lat);
    chk("recall_zero_hit", h, 0);
    chk("recall_zero_time", tm, 1);
    do_query(2'd1, 2'd0, 8'd5, 8'd5, 0, h, tm, e, lat);
    chk("unwritten_err", e, 1);
    chk("unwritten_lat", lat, 2);

    // 20 samples, ch2 high only at t=12
    do_reset();
    for (int i = 0; i < 20; i++) begin
      sample_en = 1'b1;
      sig_i = (i == 12) ? 3'b100 : {1'b0, 2'($urandom)};
      tick();
    end
    sample_en = 1'b0;
    do_query(2'd1, 2'd0, 8'd2, 8'd6, 0, h, tm, e, lat);
    chk("t3_aged_err", e, 1);
    do_query(2'd2, 2'd2, 8'd5, 8'd19, 0, h, tm, e, lat);
    chk("t3_first_hit", h, 1);
    chk("t3_first_time", tm, 12);
    chk("t3_first_lat", lat, 10);
    do_query(2'd2, 2'd1, 8'd10, 8'd8, 0, h, tm, e, lat);
    chk("reversed_err", e, 1);
    do_query(2'd1, 2'd3, 8'd10, 8'd12, 0, h, tm, e, lat);
    chk("bad_ch_err", e, 1);
    do_query(2'd1, 2'd2, 8'd12, 8'd12, 5, h, tm, e, lat);
    chk("hold_hit", h, 1);
    chk("hold_time", tm, 12);

    // overwrite abort while sampling every cycle
    rnd_samp = 1; pct = 100;
    repeat (20) tick();
    do_query(2'd2, 2'd0, mnow - 8'd15, mnow - 8'd6, 0, h, tm, e, lat);
    chk("t4_ovw_err", e, 1);
    chk("t4_ovw_lat", lat, 3);
    do_query(2'd2, 2'd0, mnow - 8'd14, mnow - 8'd5, 0, h, tm, e, lat);
    chk("t4_same_slot_err", e, 1);
    rnd_samp = 0;
    sample_en = 1'b0;

    // timestamp wrap: now preloaded to 253 by sampling
    do_reset();
    sample_en = 1'b1; sig_i = '0;
    repeat (253) tick();
    for (int i = 0; i < 6; i++) begin
      sig_i = (i == 2) ? 3'b010 : 3'b000;
      tick();
    end
    sample_en = 1'b0; sig_i = '0;
    do_query(2'd2, 2'd1, 8'd253, 8'd2, 0, h, tm, e, lat);
    chk("t5_wrap_hit", h, 1);
    chk("t5_wrap_time", tm, 255);
    chk("t5_wrap_lat", lat, 5);

    // reset in the middle of a long scan
    q_op = 2'd2; q_ch = 2'd0; q_t0 = 8'd243; q_t1 = 8'd2; q_valid = 1'b1;
    @(negedge clk);
    chk("t6_ready", q_ready_o, 1);
    tick();
    q_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", r_valid_o, 0);
    chk("t6_rst_ready", q_ready_o, 0);
    chk("t6_rst_now", now_o, 0);
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t6_no_resp", r_valid_o, 0);
      tick();
    end

    // random traffic
    rnd_samp = 1;
    for (int k = 0; k < 300; k++) begin
      logic [1:0] op, ch;
      logic [TW-1:0] t0, t1;
      pct = $urandom_range(0, 100);
      op = 2'($urandom);
      ch = 2'($urandom);
      t0 = mnow - 8'($urandom_range(0, 20));
      t1 = t0 + 8'($urandom_range(0, 20)) - 8'd2;
      if (op == 2'd0) t1 = t0;
      do_query(op, ch, t0, t1, $urandom_range(0, 3), h, tm, e, lat);
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 39) == 0) do_reset();
    end
    rnd_samp = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
